// File: rtl/intc_pkg.sv
// Shared types for the interrupt arbiter: FSM states, level/vector types and
// the number of sources compared per scan cycle.
package intc_pkg;

    localparam int GRP_W = 8;

    typedef logic [3:0] lvl_t;
    typedef logic [7:0] vec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_REQ  = 2'd2,
        ST_ACK  = 2'd3
    } intc_state_e;

endpackage

// File: rtl/intc_arb_if.sv
// CPU-side request/acknowledge bundle of the interrupt arbiter.
// Handshake: intreq_o is a level, held with int_lvl_o/int_vec_o stable while a
// request is presented; cp_ack_i is a one-cycle pulse, honoured only while intreq_o=1.
interface intc_arb_if;
    import intc_pkg::*;

    lvl_t cpu_imask_i;
    logic cp_ack_i;
    logic intreq_o;
    lvl_t int_lvl_o;
    vec_t int_vec_o;

    modport slave (
        input  cpu_imask_i,
        input  cp_ack_i,
        output intreq_o,
        output int_lvl_o,
        output int_vec_o
    );

    modport master (
        output cpu_imask_i,
        output cp_ack_i,
        input  intreq_o,
        input  int_lvl_o,
        input  int_vec_o
    );

endinterface

// File: rtl/intc_arb_grp8.sv
// Combinational winner of one group of sources: highest level, lowest index on ties.
module intc_arb_grp8
    import intc_pkg::*;
(
    input  logic [GRP_W-1:0] req_i,
    input  lvl_t [GRP_W-1:0] lvl_i,
    output lvl_t             win_lvl_o,
    output logic [2:0]       win_idx_o
);

    lvl_t       best_lvl;
    logic [2:0] best_idx;

    always_comb begin
        best_lvl = '0;
        best_idx = '0;
        // Strict compare keeps the earlier (lower) index on equal levels.
        for (int k = 0; k < GRP_W; k++) begin
            if (req_i[k] && (lvl_i[k] > best_lvl)) begin
                best_lvl = lvl_i[k];
                best_idx = 3'(k);
            end
        end
    end

    assign win_lvl_o = best_lvl;
    assign win_idx_o = best_idx;

endmodule

// File: rtl/intc_arb.sv
// Interrupt priority arbiter: scans 8 sources per cycle, presents the winner to
// the CPU and pulses the taken source back. Define INTC_ARB_IMASK_EN to gate on cpu_imask_i.
module intc_arb
    import intc_pkg::*;
#(
    parameter int   INT_NUM  = 64,
    parameter vec_t VEC_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INT_NUM-1:0] in_intreq_i,
    input  lvl_t [INT_NUM-1:0] rg_ilvl_i,
    output logic [INT_NUM-1:0] cp_intack_o,
    output intc_state_e        state_o,
    intc_arb_if.slave          cpu_if
);

    localparam int GRP_N = INT_NUM / GRP_W;
    localparam int IDX_W = $clog2(INT_NUM);
    localparam int CNT_W = (GRP_N > 1) ? $clog2(GRP_N) : 1;

    intc_state_e        state_q, state_d;
    logic [CNT_W-1:0]   grp_cnt_q, grp_cnt_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    lvl_t               best_lvl_q, best_lvl_d;

    logic [GRP_W-1:0]   grp_req;
    lvl_t [GRP_W-1:0]   grp_lvl;
    lvl_t               grp_win_lvl;
    logic [2:0]         grp_win_idx;

    logic               any_elig;
    logic               any_higher;
    logic               held_elig;
    logic               held_masked;
    logic               last_grp;
    logic               cand_better;
    lvl_t               scan_lvl;
    logic [IDX_W-1:0]   scan_idx;
    logic               lvl_pass;

    always_comb begin
        grp_req = '0;
        grp_lvl = '0;
        for (int g = 0; g < GRP_N; g++) begin
            if (grp_cnt_q == CNT_W'(g)) begin
                grp_req = in_intreq_i[g*GRP_W +: GRP_W];
                grp_lvl = rg_ilvl_i[g*GRP_W +: GRP_W];
            end
        end
    end

    intc_arb_grp8 u_grp8 (
        .req_i     (grp_req),
        .lvl_i     (grp_lvl),
        .win_lvl_o (grp_win_lvl),
        .win_idx_o (grp_win_idx)
    );

    // Whole-array views used while idle and while a request is held.
    always_comb begin
        any_elig   = 1'b0;
        any_higher = 1'b0;
        for (int i = 0; i < INT_NUM; i++) begin
            if (in_intreq_i[i] && (rg_ilvl_i[i] != '0))       any_elig   = 1'b1;
            if (in_intreq_i[i] && (rg_ilvl_i[i] > best_lvl_q)) any_higher = 1'b1;
        end
    end

    assign held_elig   = in_intreq_i[best_idx_q] && (rg_ilvl_i[best_idx_q] != '0);
    assign last_grp    = (grp_cnt_q == CNT_W'(GRP_N - 1));
    assign cand_better = (grp_win_lvl > best_lvl_q);
    assign scan_lvl    = cand_better ? grp_win_lvl : best_lvl_q;
    assign scan_idx    = cand_better ? IDX_W'(int'(grp_cnt_q) * GRP_W + int'(grp_win_idx))
                                     : best_idx_q;

`ifdef INTC_ARB_IMASK_EN
    assign lvl_pass    = (scan_lvl > cpu_if.cpu_imask_i);
    assign held_masked = (cpu_if.cpu_imask_i >= best_lvl_q);
`else
    logic unused_imask;
    assign lvl_pass     = 1'b1;
    assign held_masked  = 1'b0;
    assign unused_imask = ^cpu_if.cpu_imask_i;
`endif

    always_comb begin
        state_d    = state_q;
        grp_cnt_d  = grp_cnt_q;
        best_idx_d = best_idx_q;
        best_lvl_d = best_lvl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d    = ST_SCAN;
                    grp_cnt_d  = '0;
                    best_idx_d = '0;
                    best_lvl_d = '0;
                end
            end
            ST_SCAN: begin
                best_idx_d = scan_idx;
                best_lvl_d = scan_lvl;
                if (last_grp) begin
                    grp_cnt_d = '0;
                    state_d   = ((scan_lvl != '0) && lvl_pass) ? ST_REQ : ST_IDLE;
                end else begin
                    grp_cnt_d = grp_cnt_q + CNT_W'(1);
                end
            end
            ST_REQ: begin
                // Acknowledge takes precedence over withdrawal and preemption.
                if (cpu_if.cp_ack_i) begin
                    state_d = ST_ACK;
                end else if (!held_elig || held_masked) begin
                    state_d = ST_IDLE;
                end else if (any_higher) begin
                    state_d    = ST_SCAN;
                    grp_cnt_d  = '0;
                    best_idx_d = '0;
                    best_lvl_d = '0;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grp_cnt_q  <= '0;
            best_idx_q <= '0;
            best_lvl_q <= '0;
        end else begin
            state_q    <= state_d;
            grp_cnt_q  <= grp_cnt_d;
            best_idx_q <= best_idx_d;
            best_lvl_q <= best_lvl_d;
        end
    end

    logic intreq;
    lvl_t int_lvl;
    vec_t int_vec;

    always_comb begin
        intreq      = 1'b0;
        int_lvl     = '0;
        int_vec     = '0;
        cp_intack_o = '0;
        if (state_q == ST_REQ) begin
            intreq  = 1'b1;
            int_lvl = best_lvl_q;
            int_vec = VEC_BASE + vec_t'(best_idx_q);
        end
        if (state_q == ST_ACK) begin
            cp_intack_o[best_idx_q] = 1'b1;
        end
    end

    assign cpu_if.intreq_o  = intreq;
    assign cpu_if.int_lvl_o = int_lvl;
    assign cpu_if.int_vec_o = int_vec;
    assign state_o          = state_q;

endmodule

// File: doc/intc_arb.md
INTC_ARB -- requirements
Module: intc_arb

Interface
REQ-001 Parameter INT_NUM, default 64, SHALL set the number of normal interrupt sources, a multiple of 8, range 8..256.
REQ-002 Parameter VEC_BASE, default 8'h40, SHALL set the vector number of source 0.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; every flop SHALL sample on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port in_intreq_i, input, INT_NUM bits, SHALL carry the captured pending flags from the capture stage.
REQ-006 Port rg_ilvl_i, input, INT_NUM x 4 bits, SHALL carry per-source priority; level 0 means the source is disabled.
REQ-007 Port cpu_imask_i, input, 4 bits, SHALL carry the current CPU interrupt mask level.
REQ-008 Port intreq_o, output, 1 bit, SHALL be the interrupt request to the CPU.
REQ-009 Port int_lvl_o, output, 4 bits, SHALL carry the level of the presented request.
REQ-010 Port int_vec_o, output, 8 bits, SHALL carry the vector of the presented request.
REQ-011 Port cp_ack_i, input, 1 bit, SHALL be the CPU acknowledge, a one-cycle pulse.
REQ-012 Port cp_intack_o, output, INT_NUM bits, SHALL pulse one-hot back to the capture stage to clear the taken source.

Function
REQ-013 A source SHALL be eligible when in_intreq_i[i]=1 and rg_ilvl_i[i]!=0.
REQ-014 The FSM SHALL have four states: IDLE, SCAN, REQ, ACK.
REQ-015 IDLE SHALL go to SCAN on the cycle after any source is eligible.
REQ-016 SCAN SHALL examine 8 sources per cycle, using a group counter 0..INT_NUM/8-1, so a scan takes INT_NUM/8 cycles.
REQ-017 SCAN SHALL keep a best index and best level; a candidate SHALL replace the best only when its level is strictly greater.
- Ties SHALL go to the lowest index.
REQ-018 On the last group, SCAN SHALL go to REQ if the best level is nonzero and passes REQ-030; otherwise it SHALL go to IDLE.
- The counter SHALL wrap to 0 in either case.
REQ-019 In REQ:
- intreq_o SHALL be 1.
- int_lvl_o SHALL equal the best level.
- int_vec_o SHALL equal VEC_BASE + best index, modulo 256.
- All three SHALL be stable until REQ is left.
REQ-020 cp_ack_i=1 in REQ SHALL cause, on the next cycle:
- state ACK;
- cp_intack_o[best index]=1 for exactly one cycle;
- intreq_o=0.
REQ-021 ACK SHALL go to IDLE unconditionally; a new request SHALL appear no earlier than 2 + INT_NUM/8 cycles after ACK.
REQ-022 In REQ, if the held source stops being eligible (cleared by software or level set to 0), the FSM SHALL go to IDLE and intreq_o SHALL fall on the next cycle.
REQ-023 In REQ, if any eligible source has a level greater than the held level, the FSM SHALL return to SCAN (preemption) and intreq_o SHALL drop for at least the rescan.
REQ-024 If cp_ack_i coincides with withdrawal or preemption, the acknowledge SHALL win and REQ-020 SHALL apply.
REQ-025 cp_ack_i outside REQ SHALL be ignored, with no cp_intack_o pulse.
REQ-026 cp_intack_o SHALL be 0 in every state except ACK.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, group counter 0, best index 0, best level 0, intreq_o 0, int_lvl_o 0, int_vec_o 0, cp_intack_o all 0.
REQ-028 Reset asserted mid-SCAN or mid-REQ SHALL abandon the operation without any cp_intack_o pulse.
REQ-029 Release of rst_n SHALL be synchronised to clk by the instantiating level.

Configuration
REQ-030 With macro INTC_ARB_IMASK_EN defined:
- REQ SHALL be entered only if best level > cpu_imask_i;
- in REQ, a rise of cpu_imask_i to >= the held level SHALL act as a withdrawal (REQ-022).
REQ-031 Without INTC_ARB_IMASK_EN:
- cpu_imask_i SHALL be ignored;
- any nonzero best level SHALL be presented.

Structure
REQ-032 A shared package intc_pkg SHALL hold: the FSM state enum, the 4-bit level typedef, the 8-bit vector typedef, and the group width constant 8.
REQ-033 One sub-module, intc_arb_grp8, SHALL be combinational: it returns the max-level, lowest-index winner of 8 sources and is instanced once.

Verification
REQ-034 Single source: INT_NUM=64, source 5 at level 3, pending -> intreq_o=1, int_vec_o=8'h45, int_lvl_o=3, 9 cycles after pending; ack -> cp_intack_o[5] pulses for 1 cycle.
REQ-035 Tie: sources 10 and 40, both level 7 -> vector 8'h4A is presented first; after ack, 8'h68 is presented.
REQ-036 Preemption: REQ holding source 3 at level 2; source 60 rises at level 9 -> intreq_o drops, then vector 8'h7C is presented at level 9.
REQ-037 Withdrawal and collision: in REQ, in_intreq_i[best] cleared -> intreq_o=0 next cycle, no cp_intack_o; in a separate run, ack in the same cycle as the clear -> pulse still issued.
REQ-038 Mask (INTC_ARB_IMASK_EN): source level 4, cpu_imask_i=4 -> no request; cpu_imask_i=3 -> request presented.
REQ-039 Reset mid-REQ: rst_n low -> all outputs 0 immediately; no cp_intack_o pulse.
